operand_fetch_unit: RTL

- Initiator side of the 8x8 register-file interface.
- Accepts decoded instructions over a valid/ready handshake and drives the register-file read addresses.
- Captures both operands, with same-cycle write-back forwarding, into a one-entry output stage for the execute stage.
- Routes execute-stage write-back requests onto the register-file write port; the register file has combinational reads and writes on the rising edge.

---
 rtl/operand_fetch_unit.sv | 92 +++++++++
 1 files changed

// File: rtl/operand_fetch_unit.sv
// rtl/operand_fetch_unit.sv - register-file operand fetch with write-back forwarding
// One-entry output stage; held bundles are refreshed by write-back to their sources.
module operand_fetch_unit #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [ADDR_W-1:0] in_rs1,
   input  logic [ADDR_W-1:0] in_rs2,
   input  logic [ADDR_W-1:0] in_rd,
   input  logic [3:0]        in_op,
   output logic [ADDR_W-1:0] rf_read_addr1,
   output logic [ADDR_W-1:0] rf_read_addr2,
   input  logic [DATA_W-1:0] rf_read_data1,
   input  logic [DATA_W-1:0] rf_read_data2,
   input  logic              wb_valid,
   input  logic [ADDR_W-1:0] wb_addr,
   input  logic [DATA_W-1:0] wb_data,
   output logic              rf_reg_write,
   output logic [ADDR_W-1:0] rf_write_addr,
   output logic [DATA_W-1:0] rf_write_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_a,
   output logic [DATA_W-1:0] out_b,
   output logic [ADDR_W-1:0] out_rd,
   output logic [3:0]        out_op,
   output logic [7:0]        issue_count
);

   typedef enum logic {EMPTY, FULL} state_t;

   state_t            state;
   logic [ADDR_W-1:0] rs1_q;
   logic [ADDR_W-1:0] rs2_q;
   logic              accept;
   logic              fwd1;
   logic              fwd2;
   logic              hit1;
   logic              hit2;

   assign in_ready      = ~rst & ((state == EMPTY) | out_ready);
   assign accept        = in_valid & in_ready;
   assign rf_read_addr1 = in_rs1;
   assign rf_read_addr2 = in_rs2;
   assign rf_reg_write  = wb_valid & ~rst;
   assign rf_write_addr = wb_addr;
   assign rf_write_data = wb_data;
   assign out_valid     = (state == FULL);

   // The register file commits wb on this same edge, so its read port still shows the old value.
   assign fwd1 = wb_valid & (wb_addr == in_rs1);
   assign fwd2 = wb_valid & (wb_addr == in_rs2);
   assign hit1 = wb_valid & (wb_addr == rs1_q);
   assign hit2 = wb_valid & (wb_addr == rs2_q);

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= EMPTY;
         out_a       <= '0;
         out_b       <= '0;
         out_rd      <= '0;
         out_op      <= '0;
         rs1_q       <= '0;
         rs2_q       <= '0;
         issue_count <= '0;
      end else begin
         if (accept) begin
            state  <= FULL;
            out_a  <= fwd1 ? wb_data : rf_read_data1;
            out_b  <= fwd2 ? wb_data : rf_read_data2;
            out_rd <= in_rd;
            out_op <= in_op;
            rs1_q  <= in_rs1;
            rs2_q  <= in_rs2;
         end else if (state == FULL) begin
            if (out_ready)
               state <= EMPTY;
            if (hit1)
               out_a <= wb_data;
            if (hit2)
               out_b <= wb_data;
         end
         if (out_valid & out_ready)
            issue_count <= issue_count + 8'd1;
      end
   end

endmodule
